gesture_servo_ctrl: RTL

Consumes the per-frame finger-count result stream (`finger_count`, `count_valid`, `hand_detected`) from the vision front end and drives one hobby-servo PWM output for the robotic arm. The block debounces counts across frames, then maps each accepted count to a target pulse width. It slews the live pulse width toward the target once per PWM period and returns the arm to centre when the hand is lost. It sits between the finger-count analysis stage and the arm's joint pin.

---
 rtl/gesture_servo_ctrl_if.sv | 24 ++
 rtl/gesture_servo_ctrl.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/gesture_servo_ctrl_if.sv
// Finger-count result stream from the vision front end plus the servo-side outputs.
// count_valid is a one-cycle strobe with no back-pressure: the consumer samples
// finger_count/hand_detected on every cycle it is high, so back-to-back strobes are legal.
interface gesture_servo_ctrl_if;
    logic [2:0]  finger_count;
    logic        count_valid;
    logic        hand_detected;
    logic        pwm_out;
    logic [2:0]  gesture_cmd;
    logic        cmd_valid;
    logic        hand_present;
    logic [15:0] pulse_us;
    logic        at_target;

    modport master (
        output finger_count, count_valid, hand_detected,
        input  pwm_out, gesture_cmd, cmd_valid, hand_present, pulse_us, at_target
    );

    modport slave (
        input  finger_count, count_valid, hand_detected,
        output pwm_out, gesture_cmd, cmd_valid, hand_present, pulse_us, at_target
    );
endinterface

// File: rtl/gesture_servo_ctrl.sv
// Debounces per-frame finger counts into gesture commands and drives one servo PWM
// whose pulse width slews toward the commanded target once per PWM period.
module gesture_servo_ctrl #(
    parameter int CLK_HZ        = 100_000_000,
    parameter int STABLE_FRAMES = 3,
    parameter int LOST_FRAMES   = 8,
    parameter int PERIOD_US     = 20000,
    parameter int MIN_US        = 1000,
    parameter int MAX_US        = 2000,
    parameter int STEP_US       = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    gesture_servo_ctrl_if.slave bus
);

    localparam int DIV = CLK_HZ / 1_000_000;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
    localparam logic [15:0]   PCNT_LAST  = 16'(PERIOD_US - 1);
    localparam logic [15:0]   CENTER_US  = 16'((MIN_US + MAX_US) / 2);
    localparam logic [15:0]   STEP       = 16'(STEP_US);
    localparam logic [3:0]    RUN_MAX    = 4'(STABLE_FRAMES);
    localparam logic [7:0]    LOST_LIM   = 8'(LOST_FRAMES);

    // Multiply before dividing so intermediate counts keep their fractional share.
    localparam logic [15:0] TGT0 = 16'(MIN_US + 0 * (MAX_US - MIN_US) / 5);
    localparam logic [15:0] TGT1 = 16'(MIN_US + 1 * (MAX_US - MIN_US) / 5);
    localparam logic [15:0] TGT2 = 16'(MIN_US + 2 * (MAX_US - MIN_US) / 5);
    localparam logic [15:0] TGT3 = 16'(MIN_US + 3 * (MAX_US - MIN_US) / 5);
    localparam logic [15:0] TGT4 = 16'(MIN_US + 4 * (MAX_US - MIN_US) / 5);
    localparam logic [15:0] TGT5 = 16'(MIN_US + 5 * (MAX_US - MIN_US) / 5);

    function automatic logic [15:0] tgt_of(input logic [2:0] n);
        case (n)
            3'd0:    tgt_of = TGT0;
            3'd1:    tgt_of = TGT1;
            3'd2:    tgt_of = TGT2;
            3'd3:    tgt_of = TGT3;
            3'd4:    tgt_of = TGT4;
            default: tgt_of = TGT5;
        endcase
    endfunction

    logic [PW-1:0] r_presc;
    logic [15:0]   r_pcnt;
    logic [15:0]   r_pulse;
    logic [15:0]   r_target;
    logic          r_pwm;
    logic [2:0]    r_cmd;
    logic          r_cmd_valid;
    logic          r_hand_present;
    logic [2:0]    r_cand;
    logic [3:0]    r_run;
    logic [7:0]    r_lost;
    logic          r_has_cmd;

    logic          w_tick;
    logic          w_boundary;
    logic [2:0]    w_clamped;
    logic [3:0]    w_run_next;
    logic          w_accept;
    logic [7:0]    w_lost_next;
    logic          w_lost_hit;
    logic          w_up;
    logic [15:0]   w_gap;
    logic [15:0]   w_step;
    logic [15:0]   w_pulse_next;

    assign w_tick     = (r_presc == PRESC_LAST);
    assign w_boundary = w_tick && (r_pcnt == PCNT_LAST);

    assign w_clamped  = (bus.finger_count > 3'd5) ? 3'd5 : bus.finger_count;
    assign w_run_next = (w_clamped != r_cand) ? 4'd1 :
                        (r_run >= RUN_MAX)    ? RUN_MAX : r_run + 4'd1;
    // A saturated run on the already-accepted value must not re-announce it.
    assign w_accept   = bus.count_valid && bus.hand_detected && (w_run_next == RUN_MAX) &&
                        (!r_has_cmd || (w_clamped != r_cmd));
    assign w_lost_next = (r_lost == 8'hFF) ? 8'hFF : r_lost + 8'd1;
    assign w_lost_hit  = (w_lost_next == LOST_LIM);

    assign w_up         = (r_target > r_pulse);
    assign w_gap        = w_up ? (r_target - r_pulse) : (r_pulse - r_target);
    assign w_step       = (w_gap < STEP) ? w_gap : STEP;
    assign w_pulse_next = w_up ? (r_pulse + w_step) : (r_pulse - w_step);

    // Width only changes at the period boundary, so every emitted pulse is whole.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_pcnt  <= '0;
            r_pulse <= CENTER_US;
            r_pwm   <= 1'b0;
        end else begin
            r_pwm   <= (r_pcnt < r_pulse);
            r_presc <= w_tick ? '0 : r_presc + PW'(1);
            if (w_tick) begin
                r_pcnt <= (r_pcnt == PCNT_LAST) ? 16'd0 : r_pcnt + 16'd1;
            end
            if (w_boundary) begin
                r_pulse <= w_pulse_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_target       <= CENTER_US;
            r_cmd          <= 3'd0;
            r_cmd_valid    <= 1'b0;
            r_hand_present <= 1'b0;
            r_cand         <= 3'd0;
            r_run          <= 4'd0;
            r_lost         <= 8'd0;
            r_has_cmd      <= 1'b0;
        end else begin
            r_cmd_valid <= 1'b0;
            if (bus.count_valid) begin
                if (bus.hand_detected) begin
                    r_lost         <= 8'd0;
                    r_hand_present <= 1'b1;
                    r_cand         <= w_clamped;
                    r_run          <= w_run_next;
                    if (w_accept) begin
                        r_cmd       <= w_clamped;
                        r_has_cmd   <= 1'b1;
                        r_target    <= tgt_of(w_clamped);
                        r_cmd_valid <= 1'b1;
                    end
                end else begin
                    r_run  <= 4'd0;
                    r_cand <= 3'd0;
                    r_lost <= w_lost_next;
                    // gesture_cmd is kept; clearing has_cmd lets the same gesture re-announce.
                    if (w_lost_hit) begin
                        r_hand_present <= 1'b0;
                        r_target       <= CENTER_US;
                        r_has_cmd      <= 1'b0;
                    end
                end
            end
        end
    end

    assign bus.pwm_out      = r_pwm;
    assign bus.gesture_cmd  = r_cmd;
    assign bus.cmd_valid    = r_cmd_valid;
    assign bus.hand_present = r_hand_present;
    assign bus.pulse_us     = r_pulse;
    assign bus.at_target    = (r_pulse == r_target);

endmodule
